// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises rx, finds the start bit, samples each bit at mid-bit
// and emits one strobe per data bit, then checks the stop bit.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic bit_out,
    output logic bit_strobe,
    output logic byte_valid,
    output logic frame_err,
    output logic busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   bit_d, strobe_d, valid_d, ferr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // Synchroniser presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            bit_out    <= 1'b0;
            bit_strobe <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            bit_out    <= bit_d;
            bit_strobe <= strobe_d;
            byte_valid <= valid_d;
            frame_err  <= ferr_d;
            busy       <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bit_d    = bit_out;
        strobe_d = 1'b0;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Half a bit in: a line that has gone high again was only a glitch.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    bit_d    = rx_s;
                    strobe_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Hold off until the line returns high so a long break reports once.
            BRK: begin
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboarded bench for uart_rx_sampler: expected bits/frame results queued at drive time,
// popped and compared as strobes and frame pulses appear.
module tb_uart_rx_sampler;
    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic bit_out, bit_strobe, byte_valid, frame_err, busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } evt_t;

    logic exp_bits[$];
    evt_t exp_evt[$];
    int   checks = 0;
    int   errs   = 0;
    int   cyc    = 0;
    int   last_str = 0;
    int   n_str    = 0;
    int   last_bv  = 0;
    int   prev_bv  = 0;
    logic [7:0] sipo = '0;

    uart_rx_sampler #(.CLKS_PER_BIT(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .bit_out   (bit_out),
        .bit_strobe(bit_strobe),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every DUT pulse.
    always @(negedge clk) begin
        if (reset) begin
            sipo  = '0;
            n_str = 0;
        end else begin
            if (bit_strobe || byte_valid || frame_err)
                chk("excl", 32'(bit_strobe) + 32'(byte_valid) + 32'(frame_err), 1);
            if (bit_strobe) begin
                if (n_str > 0) chk("strobe_gap", cyc - last_str, 16);
                last_str = cyc;
                n_str++;
                sipo = {bit_out, sipo[7:1]};
                if (exp_bits.size() == 0) chk("strobe_unexp", 1, 0);
                else chk("bit", bit_out, exp_bits.pop_front());
            end
            if (byte_valid || frame_err) begin
                chk("end_gap", cyc - last_str, 16);
                n_str = 0;
                if (exp_evt.size() == 0) chk("evt_unexp", {byte_valid, frame_err}, 0);
                else begin
                    evt_t e;
                    e = exp_evt.pop_front();
                    chk("evt_kind", frame_err, e.err);
                    chk("byte", sipo, e.data);
                end
                if (byte_valid) begin
                    prev_bv = last_bv;
                    last_bv = cyc;
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input logic stop, input int stop_len);
        evt_t e;
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        e.err  = ~stop;
        e.data = d;
        exp_evt.push_back(e);
        drive(1'b0, per);
        for (int i = 0; i < 8; i++) drive(d[i], per);
        drive(stop, stop_len);
        rx = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {bit_out, bit_strobe, byte_valid, frame_err, busy}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 5);

        // 1: nominal frame
        send_frame(8'hA5, 16, 1'b1, 16);
        drive(1'b1, 10);

        // 2: short low glitch is rejected at the half-bit check
        drive(1'b0, 4);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        drive(1'b1, 10);

        // 3: stop bit low held 40 cycles -> one frame_err, busy until line rises
        send_frame(8'h3C, 16, 1'b0, 40);
        @(negedge clk);
        chk("brk_busy_hi", busy, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("brk_busy_lo", busy, 0);
        drive(1'b1, 5);
        send_frame(8'h55, 16, 1'b1, 16);
        drive(1'b1, 10);

        // 4: reset after the third strobe of 0xFF aborts silently
        for (int i = 0; i < 3; i++) exp_bits.push_back(1'b1);
        drive(1'b0, 16);
        drive(1'b1, 48);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out", {bit_out, bit_strobe, byte_valid, frame_err, busy}, 0);
        chk("midrst_strobes", exp_bits.size(), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 5);
        send_frame(8'h81, 16, 1'b1, 16);
        drive(1'b1, 10);

        // 5: back-to-back frames, no idle between
        send_frame(8'h00, 16, 1'b1, 16);
        send_frame(8'hFF, 16, 1'b1, 16);
        chk("b2b_gap", last_bv - prev_bv, 160);
        drive(1'b1, 10);

        // 6: slow and fast bit periods; at 15 clk/bit the bit-6 sample lands on the
        // bit-6/bit-7 boundary, so the fast frame keeps bits 6 and 7 equal.
        send_frame(8'h96, 17, 1'b1, 17);
        drive(1'b1, 10);
        send_frame(8'hD6, 15, 1'b1, 15);
        drive(1'b1, 20);

        chk("bits_left", exp_bits.size(), 0);
        chk("evts_left", exp_evt.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
